// File: rtl/cc_mem_rd_responder_pkg.sv
// Shared AXI read-side encodings, line geometry and FSM state for the cache-controller memory responder.
package cc_axi_pkg;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 64;
  localparam int LINE_W     = 512;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  localparam logic [3:0] LEN_LINE = 4'(LINE_BEATS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_FETCH, ST_LOAD, ST_BURST} state_t;

  // Registered request: line address, critical word and protocol-error flag.
  typedef struct packed {
    logic [25:0] line;
    logic [2:0]  word;
    logic        err;
  } rd_req_t;
endpackage

// File: rtl/cc_mem_rd_responder_if.sv
// AR/R channel plus backing line-read port; slave = responder, master = requester/memory side.
interface cc_mem_rd_responder_if #(parameter int ID_W = 4);
  logic [ID_W-1:0] arid_i;
  logic [31:0]     araddr_i;
  logic [3:0]      arlen_i;
  logic [1:0]      arburst_i;
  logic            arvalid_i;
  logic            arready_o;
  logic            line_rden_o;
  logic [25:0]     line_raddr_o;
  logic [511:0]    line_rdata_i;
  logic [ID_W-1:0] rid_o;
  logic [63:0]     rdata_o;
  logic [1:0]      rresp_o;
  logic            rlast_o;
  logic            rvalid_o;
  logic            rready_i;

  modport slave (
    input  arid_i, araddr_i, arlen_i, arburst_i, arvalid_i, line_rdata_i, rready_i,
    output arready_o, line_rden_o, line_raddr_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output arid_i, araddr_i, arlen_i, arburst_i, arvalid_i, line_rdata_i, rready_i,
    input  arready_o, line_rden_o, line_raddr_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/cc_mem_rd_responder_beat_mux.sv
// Selects one 64-bit beat from a 512-bit line; word w sits at [511-64w -: 64].
module cc_line_beat_mux
  import cc_axi_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [2:0]        ptr,
  output logic [BEAT_W-1:0] beat
);
  always_comb beat = line[LINE_W-1-BEAT_W*int'(ptr) -: BEAT_W];
endmodule

// File: rtl/cc_mem_rd_responder.sv
// AXI R-channel memory responder: one line per AR, 8 wrap-order beats from the critical word.
// Optional CC_RD_PROT_CHK_EN: non-line bursts (arlen!=7 or non-WRAP) answer 8 zero beats with SLVERR.
module cc_mem_rd_responder
  import cc_axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MEM_DELAY = 0
) (
  input logic clk,
  input logic rst,
  cc_mem_rd_responder_if.slave bus
);
  state_t            state, state_nxt;
  logic              live;
  rd_req_t           req;
  logic [ID_W-1:0]   id;
  logic [2:0]        ptr, cnt;
  logic [7:0]        dly;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat;
  logic              ar_hs, r_hs, illegal;

`ifdef CC_RD_PROT_CHK_EN
  assign illegal = (bus.arlen_i != LEN_LINE) || (bus.arburst_i != BURST_WRAP);
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus.araddr_i[2:0];
`else
  assign illegal = 1'b0;
  logic unused_ar;
  assign unused_ar = ^{bus.arlen_i, bus.arburst_i, bus.araddr_i[2:0]};
`endif

  // live keeps arready low for the reset cycle itself
  assign ar_hs = bus.arvalid_i && (state == ST_IDLE) && live;
  assign r_hs  = (state == ST_BURST) && bus.rready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ar_hs) state_nxt = illegal ? ST_BURST : ((MEM_DELAY > 0) ? ST_WAIT : ST_FETCH);
      ST_WAIT:  if (dly == 8'(MEM_DELAY - 1)) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_BURST;
      ST_BURST: if (r_hs && cnt == 3'd7) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.arready_o    = (state == ST_IDLE) && live;
    bus.line_rden_o  = (state == ST_FETCH);
    bus.line_raddr_o = req.line;
    bus.rvalid_o     = (state == ST_BURST);
    bus.rlast_o      = (state == ST_BURST) && (cnt == 3'd7);
    bus.rid_o        = id;
    bus.rdata_o      = ((state == ST_BURST) && !req.err) ? beat : '0;
    bus.rresp_o      = ((state == ST_BURST) && req.err) ? RRESP_SLVERR : RRESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live <= 1'b0;
      req  <= '0;
      id   <= '0;
      ptr  <= '0;
      cnt  <= '0;
      dly  <= '0;
      line <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        ST_IDLE: if (ar_hs) begin
          id   <= bus.arid_i;
          req  <= '{line: bus.araddr_i[31:6], word: bus.araddr_i[5:3], err: illegal};
          ptr  <= bus.araddr_i[5:3];
          cnt  <= '0;
          dly  <= '0;
        end
        ST_WAIT: dly <= dly + 8'd1;
        ST_LOAD: begin
          line <= bus.line_rdata_i;
          ptr  <= req.word;
          cnt  <= '0;
        end
        ST_BURST: if (r_hs) begin
          ptr <= ptr + 3'd1;
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  cc_line_beat_mux u_mux (.line(line), .ptr(ptr), .beat(beat));
endmodule

// File: tb/tb_cc_mem_rd_responder.sv
// Directed bench: two responders (MEM_DELAY 0 and 3) with a line-memory model driving each.
module tb_cc_mem_rd_responder;
  import cc_axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  cc_mem_rd_responder_if #(.ID_W(4)) b0 ();
  cc_mem_rd_responder_if #(.ID_W(4)) b3 ();

  cc_mem_rd_responder #(.ID_W(4), .MEM_DELAY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  cc_mem_rd_responder #(.ID_W(4), .MEM_DELAY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [63:0] wd(input logic [25:0] la, input logic [2:0] w);
    return {6'h2A, la, 24'h5A5A5A, 5'h00, w};
  endfunction

  function automatic logic [511:0] mkline(input logic [25:0] la);
    logic [511:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[511-64*w -: 64] = wd(la, 3'(w));
    return l;
  endfunction

  // Memory: data valid only in the cycle after rden, garbage otherwise.
  logic [511:0] garbage = {8{64'hBAD0_BAD1_BAD2_BAD3}};
  logic         p0_rden = 1'b0, p3_rden = 1'b0;
  logic [25:0]  p0_addr = '0, p3_addr = '0;
  always begin
    @(posedge clk); #1;
    b0.line_rdata_i = p0_rden ? mkline(p0_addr) : garbage;
    b3.line_rdata_i = p3_rden ? mkline(p3_addr) : garbage;
    p0_rden = b0.line_rden_o; p0_addr = b0.line_raddr_o;
    p3_rden = b3.line_rden_o; p3_addr = b3.line_raddr_o;
  end

  typedef struct {
    logic        arready, rvalid, rlast, rden;
    logic [25:0] raddr;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
  } obs_t;

  function automatic obs_t ob(input int s);
    obs_t o;
    if (s == 0) o = '{b0.arready_o, b0.rvalid_o, b0.rlast_o, b0.line_rden_o, b0.line_raddr_o, b0.rdata_o, b0.rid_o, b0.rresp_o};
    else        o = '{b3.arready_o, b3.rvalid_o, b3.rlast_o, b3.line_rden_o, b3.line_raddr_o, b3.rdata_o, b3.rid_o, b3.rresp_o};
    return o;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int s, input logic v, input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] len, input logic [1:0] bt);
    if (s == 0) begin b0.arvalid_i = v; b0.arid_i = id; b0.araddr_i = a; b0.arlen_i = len; b0.arburst_i = bt; end
    else        begin b3.arvalid_i = v; b3.arid_i = id; b3.araddr_i = a; b3.arlen_i = len; b3.arburst_i = bt; end
  endtask

  task automatic set_rr(input int s, input logic r);
    if (s == 0) b0.rready_i = r; else b3.rready_i = r;
  endtask

  // Issue one AR, check latency/line read, then collect 8 beats against the wrap-order model.
  task automatic burst(input int s, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [1:0] bt, input int lat_exp, input int rr_mode, input bit err,
                       input bit hold2, input logic [31:0] a2);
    obs_t o;
    int cyc, rden_n, hs, k;
    logic [25:0] la, ra;
    logic [2:0]  w0;
    logic        rr;
    la = a[31:6]; w0 = a[5:3]; ra = '0;
    o = ob(s);
    chk("arready_idle", o.arready, 1);
    set_ar(s, 1'b1, id, a, len, bt);
    step();
    set_ar(s, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    cyc = 1; rden_n = 0;
    o = ob(s);
    while (!o.rvalid && cyc < 64) begin
      chk("arready_busy", o.arready, 0);
      if (o.rden) begin rden_n++; ra = o.raddr; end
      step(); cyc++; o = ob(s);
    end
    chk("first_rvalid_lat", cyc, lat_exp);
    chk("rden_count", rden_n, err ? 0 : 1);
    if (!err) chk("line_raddr", ra, la);
    if (hold2) set_ar(s, 1'b1, id + 4'd1, a2, LEN_LINE, BURST_WRAP);
    hs = 0; k = 0;
    while (hs < 8 && k < 64) begin
      rr = (rr_mode == 0) ? 1'b1 : (k % 3 == 0);
      set_rr(s, rr);
      o = ob(s);
      chk("rvalid", o.rvalid, 1);
      chk("rdata", o.rdata, err ? 64'h0 : wd(la, w0 + 3'(hs)));
      chk("rlast", o.rlast, hs == 7);
      chk("rid", o.rid, id);
      chk("rresp", o.rresp, err ? RRESP_SLVERR : RRESP_OKAY);
      if (hold2) chk("arready_during_burst", o.arready, 0);
      if (rr && o.rvalid) hs++;
      step(); k++;
    end
    chk("beat_count", hs, 8);
    o = ob(s);
    chk("arready_after", o.arready, 1);
    chk("rvalid_after", o.rvalid, 0);
  endtask

  initial begin
    obs_t o;
    int   cyc, hs;
    rst = 1'b1;
    set_ar(0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    set_ar(3, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    set_rr(0, 1'b0); set_rr(3, 1'b0);
    repeat (2) step();

    for (int s = 0; s < 2; s++) begin
      o = ob(s == 0 ? 0 : 3);
      chk("rst_arready", o.arready, 0);
      chk("rst_rvalid", o.rvalid, 0);
      chk("rst_rlast", o.rlast, 0);
      chk("rst_rden", o.rden, 0);
      chk("rst_rdata", o.rdata, 0);
      chk("rst_rid", o.rid, 0);
      chk("rst_rresp", o.rresp, 0);
    end
    rst = 1'b0;
    step();

    // Aligned line, then critical word 5, then stalled R channel
    burst(0, 4'd3, 32'h0000_1040, LEN_LINE, BURST_WRAP, 3, 0, 1'b0, 1'b0, 32'h0);
    burst(0, 4'd5, 32'h0000_1068, LEN_LINE, BURST_WRAP, 3, 0, 1'b0, 1'b0, 32'h0);
    burst(0, 4'd7, 32'h0000_3F90, LEN_LINE, BURST_WRAP, 3, 1, 1'b0, 1'b0, 32'h0);

    // MEM_DELAY=3 with a second AR parked during the first burst
    burst(3, 4'd1, 32'h0000_2000, LEN_LINE, BURST_WRAP, 6, 0, 1'b0, 1'b1, 32'h0000_20F8);
    burst(3, 4'd2, 32'h0000_20F8, LEN_LINE, BURST_WRAP, 6, 1, 1'b0, 1'b0, 32'h0);

    // Reset on the 4th beat abandons the burst
    set_ar(0, 1'b1, 4'd9, 32'h0000_0100, LEN_LINE, BURST_WRAP);
    step();
    set_ar(0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    set_rr(0, 1'b1);
    cyc = 1; o = ob(0);
    while (!o.rvalid && cyc < 64) begin step(); cyc++; o = ob(0); end
    chk("rst_burst_lat", cyc, 3);
    hs = 0;
    while (hs < 3 && cyc < 64) begin
      o = ob(0);
      if (o.rvalid) hs++;
      step(); cyc++;
    end
    o = ob(0);
    chk("rst_beat4_rvalid", o.rvalid, 1);
    chk("rst_beat4_rdata", o.rdata, wd(26'h4, 3'd3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    o = ob(0);
    chk("midrst_rvalid", o.rvalid, 0);
    chk("midrst_arready", o.arready, 0);
    chk("midrst_rlast", o.rlast, 0);
    step();
    burst(0, 4'd4, 32'h0000_0578, LEN_LINE, BURST_WRAP, 3, 0, 1'b0, 1'b0, 32'h0);

    // Non-line burst: SLVERR beats when protocol checking is built in, normal otherwise
`ifdef CC_RD_PROT_CHK_EN
    burst(0, 4'd6, 32'h0000_1040, 4'd3, BURST_WRAP, 1, 0, 1'b1, 1'b0, 32'h0);
    burst(0, 4'd6, 32'h0000_1048, LEN_LINE, BURST_INCR, 1, 1, 1'b1, 1'b0, 32'h0);
`else
    burst(0, 4'd6, 32'h0000_1040, 4'd3, BURST_WRAP, 3, 0, 1'b0, 1'b0, 32'h0);
    burst(0, 4'd6, 32'h0000_1048, LEN_LINE, BURST_INCR, 3, 1, 1'b0, 1'b0, 32'h0);
`endif
    burst(0, 4'd8, 32'h0000_1040, LEN_LINE, BURST_WRAP, 3, 0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cc_mem_rd_responder.md
Name: cc_mem_rd_responder

Overview:
AXI read-side responder: the memory end of the R channel consumed by the cache fill path.
- Accepts one AR request at a time and reads the 64-byte line from a backing line-read port.
- Returns the line as 8 x 64-bit beats in wrap order, starting at the critical word addr[5:3], with rlast on beat 8.
- Serves as the memory model and bridge in the cache-controller subsystem.

Parameters:
ID_W, 4, width of arid/rid
MEM_DELAY, 0, extra wait cycles between AR handshake and line read (0..255)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
arid_i  in  ID_W  request ID
araddr_i  in  32  byte address; [31:6] selects the line, [5:3] is the critical word
arlen_i  in  4  burst length-1 (legal value 7)
arburst_i  in  2  burst type (legal value WRAP=2'b10)
arvalid_i  in  1  AR valid
arready_o  out  1  AR ready
line_rden_o  out  1  line read strobe
line_raddr_o  out  26  line address
line_rdata_i  in  512  line data, valid the cycle after line_rden_o; word w occupies [511-64w -: 64]
rid_o  out  ID_W  response ID
rdata_o  out  64  beat data
rresp_o  out  2  response code
rlast_o  out  1  last beat
rvalid_o  out  1  R valid
rready_i  in  1  R ready

Behaviour:
- Reset values: arready_o=0, rvalid_o=0, rlast_o=0, line_rden_o=0, rdata_o=0, rid_o=0, rresp_o=0; FSM=IDLE; beat counter=0.
- Reset is synchronous, active-high, and takes priority in every state. Asserting it mid-burst abandons the burst; rvalid_o is 0 the next cycle.
- FSM states:
  - IDLE: arready_o=1. On arvalid_i&arready_o, register arid, araddr[31:3] and legality; go to WAIT if MEM_DELAY>0, else FETCH.
  - WAIT: count MEM_DELAY cycles, then go to FETCH.
  - FETCH: line_rden_o=1 for exactly one cycle, line_raddr_o=araddr[31:6]; go to LOAD.
  - LOAD: capture line_rdata_i into the 512-bit line buffer; load the 3-bit beat pointer with araddr[5:3]; clear the beat counter; go to BURST.
  - BURST: rvalid_o=1, rdata_o=buffer[511-64*ptr -: 64], rid_o=registered ID, rlast_o=(cnt==7). On rvalid&rready: ptr=ptr+1 mod 8 (wraps 7->0), cnt=cnt+1. On the handshake with rlast_o=1, go to IDLE.
- arready_o is 0 in every state except IDLE, so at most one request is outstanding.
- Latency with MEM_DELAY=0: AR handshake in cycle T, rden at T+1, capture at T+2, first rvalid at T+3. Each extra MEM_DELAY cycle adds one.
- Back-to-back: arready_o=1 the cycle after the last beat handshake.
- While rvalid_o=1 and rready_i=0, rdata_o, rid_o, rresp_o and rlast_o hold stable; rvalid_o never drops before its handshake.
- A handshake on every cycle gives 8 beats in 8 consecutive cycles.
- line_rdata_i is sampled only in LOAD and ignored at all other times.
- rresp_o=OKAY (2'b00) unless the optional feature flags an error.

Optional Feature:
CC_RD_PROT_CHK_EN
- Defined: in IDLE, a request with arlen_i!=7 or arburst_i!=WRAP is flagged illegal.
  - No line read is issued; FETCH/LOAD are skipped and the FSM goes straight to BURST.
  - Eight beats are still returned, with rdata_o=0 and rresp_o=SLVERR (2'b10) on every beat; rlast_o on beat 8.
- Undefined: arlen_i and arburst_i are ignored; every request returns 8 wrap-order beats with OKAY.

Decomposition:
- Package cc_axi_pkg:
  - burst encodings (FIXED/INCR/WRAP)
  - RRESP codes (OKAY, SLVERR)
  - LINE_BEATS=8, BEAT_W=64, LINE_W=512
  - FSM state enum (IDLE, WAIT, FETCH, LOAD, BURST)
- One natural sub-module: cc_line_beat_mux, a combinational 512->64 selector indexed by the 3-bit beat pointer using the [511-64w] word mapping. The FSM, counters and line buffer stay in the top.

Test Plan:
- araddr=0x0000_1040, arid=3, rready=1 constantly -> line_raddr=0x41 at T+1; beats carry words 0..7; rid=3; rlast on the 8th beat only; rvalid first seen at T+3.
- araddr=0x0000_1068 (word 5) -> beat order 5,6,7,0,1,2,3,4; rlast on word 4; rresp=OKAY throughout.
- rready toggled 1,0,0,1,... during a burst -> rdata/rlast hold during stalls; exactly 8 handshakes; arready=1 the cycle after the last.
- MEM_DELAY=3, second AR presented during a burst -> arready=0 until burst end; second burst's first rvalid 6 cycles after its handshake.
- rst asserted on the 4th beat -> next cycle rvalid=0, arready=0; the cycle after rst deasserts, arready=1 and a new request completes normally.
- CC_RD_PROT_CHK_EN defined, arlen=3 -> no line_rden; 8 beats with rdata=0 and rresp=2'b10. Undefined, same stimulus -> normal 8 OKAY beats.
